// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC priority controller: acknowledge FSM
// states and the rotating find-first used by both priority encoders.
package pic_pkg;

  localparam int unsigned NUM_IR = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    GAP  = 2'd2,
    ACK2 = 2'd3
  } ack_state_t;

  // Returns {valid, level} of the first set bit scanning lowest+1, lowest+2, ... lowest.
  function automatic logic [3:0] rot_first(input logic [NUM_IR-1:0] vec,
                                           input logic [2:0]        lowest);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    // Walk the order backwards so the earliest hit overwrites later ones.
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      idx = lowest + 3'(k) + 3'd1;
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/pic_rot_prio_enc.sv
// Combinational rotating priority encoder: first set bit after the current
// lowest-priority level, wrapping modulo 8.
module pic_rot_prio_enc
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec_i,
  input  logic [2:0]        lowest_i,
  output logic              valid_o,
  output logic [2:0]        level_o
);

  logic [3:0] first;

  assign first   = rot_first(vec_i, lowest_i);
  assign valid_o = first[3];
  assign level_o = first[2:0];

endmodule

// File: rtl/pic_priority_ctrl.sv
// PIC priority resolver, INTA sequencer and in-service register with EOI handling.
// Optional PIC_AUTO_EOI_EN adds the aeoi input (automatic EOI on the 2nd INTA rise).
module pic_priority_ctrl
  import pic_pkg::*;
#(
  parameter logic [2:0] LOWEST_RST  = 3'd7,
  parameter logic [2:0] SPURIOUS_IR = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta_n,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
`ifdef PIC_AUTO_EOI_EN
  input  logic       aeoi,
`endif
  output logic       int_out,
  output logic [2:0] highest_priority,
  output logic       current_pulse,
  output logic       vector_valid,
  output logic [7:0] isr,
  output ack_state_t dbg_state
);

  // INTA handshake: each INTA pulse is one low phase of inta_n; edges are taken
  // against the registered copy, so a fall/rise acts on the clock it is first seen.
  ack_state_t state_q, state_d;
  logic       inta_q;
  logic       int_out_q, int_out_d;
  logic [2:0] hp_q, hp_d;
  logic       cp_q, cp_d;
  logic       vv_q, vv_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] lowest_q, lowest_d;

  logic       inta_fall, inta_rise;
  logic [7:0] req;
  logic       req_valid, isr_valid, pend_valid;
  logic [2:0] req_level, isr_level, req_rank, isr_rank;
  logic [7:0] isr_set, isr_clr;
  logic       ack_done, auto_eoi, eoi_hit, aeoi_hit;
  logic [2:0] eoi_lvl;

`ifdef PIC_AUTO_EOI_EN
  assign auto_eoi = aeoi;
`else
  assign auto_eoi = 1'b0;
`endif

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;
  assign req       = irr & ~imr;

  pic_rot_prio_enc u_req_enc (
    .vec_i    (req),
    .lowest_i (lowest_q),
    .valid_o  (req_valid),
    .level_o  (req_level)
  );

  pic_rot_prio_enc u_isr_enc (
    .vec_i    (isr_q),
    .lowest_i (lowest_q),
    .valid_o  (isr_valid),
    .level_o  (isr_level)
  );

  // Rank 0 is the highest priority; a request must strictly outrank the active service.
  assign req_rank   = req_level - lowest_q - 3'd1;
  assign isr_rank   = isr_level - lowest_q - 3'd1;
  assign pend_valid = req_valid & (~isr_valid | (req_rank < isr_rank));

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state_q   <= IDLE;
      inta_q    <= 1'b1;
      int_out_q <= 1'b0;
      hp_q      <= 3'd0;
      cp_q      <= 1'b0;
      vv_q      <= 1'b0;
      isr_q     <= 8'h00;
      lowest_q  <= LOWEST_RST;
    end else begin
      state_q   <= state_d;
      inta_q    <= inta_n;
      int_out_q <= int_out_d;
      hp_q      <= hp_d;
      cp_q      <= cp_d;
      vv_q      <= vv_d;
      isr_q     <= isr_d;
      lowest_q  <= lowest_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (inta_fall) state_d = ACK1;
      ACK1:    if (inta_rise) state_d = GAP;
      GAP:     if (inta_fall) state_d = ACK2;
      ACK2:    if (inta_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs_next
    int_out_d = 1'b0;
    hp_d      = hp_q;
    cp_d      = cp_q;
    vv_d      = vv_q;
    isr_set   = 8'h00;
    ack_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inta_fall) begin
          hp_d = pend_valid ? req_level : SPURIOUS_IR;
          if (pend_valid) isr_set[req_level] = 1'b1;
        end else begin
          int_out_d = pend_valid;
        end
      end
      ACK1: if (inta_rise) cp_d = 1'b1;
      GAP:  if (inta_fall) vv_d = 1'b1;
      ACK2: begin
        if (inta_rise) begin
          vv_d     = 1'b0;
          cp_d     = 1'b0;
          ack_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // EOI wins the rotation pointer over an automatic EOI landing in the same cycle.
  always_comb begin : eoi_logic
    eoi_lvl  = eoi_specific ? eoi_level : isr_level;
    eoi_hit  = eoi_valid & isr_q[eoi_lvl];
    aeoi_hit = ack_done & auto_eoi & isr_q[hp_q];
    isr_clr  = 8'h00;
    lowest_d = lowest_q;
    if (aeoi_hit) begin
      isr_clr[hp_q] = 1'b1;
      if (rotate_on_eoi) lowest_d = hp_q;
    end
    if (eoi_hit) begin
      isr_clr[eoi_lvl] = 1'b1;
      if (rotate_on_eoi) lowest_d = eoi_lvl;
    end
    isr_d = (isr_q & ~isr_clr) | isr_set;
  end

  assign int_out          = int_out_q;
  assign highest_priority = hp_q;
  assign current_pulse    = cp_q;
  assign vector_valid     = vv_q;
  assign isr              = isr_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_pic_priority_ctrl.sv
// Bench for pic_priority_ctrl: directed vector table, hand sequences for the
// multi-cycle cases, then random traffic against a rule-level model.
module tb_pic_priority_ctrl;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irr, imr;
  logic       inta_n, eoi_valid, eoi_specific, rotate_on_eoi;
  logic [2:0] eoi_level;
  logic       aeoi;
  logic       int_out, current_pulse, vector_valid;
  logic [2:0] highest_priority;
  logic [7:0] isr;
  ack_state_t dbg_state;

  int total = 0;
  int bad   = 0;

  pic_priority_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .irr              (irr),
    .imr              (imr),
    .inta_n           (inta_n),
    .eoi_valid        (eoi_valid),
    .eoi_specific     (eoi_specific),
    .eoi_level        (eoi_level),
    .rotate_on_eoi    (rotate_on_eoi),
`ifdef PIC_AUTO_EOI_EN
    .aeoi             (aeoi),
`endif
    .int_out          (int_out),
    .highest_priority (highest_priority),
    .current_pulse    (current_pulse),
    .vector_valid     (vector_valid),
    .isr              (isr),
    .dbg_state        (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (rule level) ----------------
  int         m_low, m_phase;
  logic [7:0] m_isr;
  logic       m_int, m_cp, m_vv, m_inta;
  int         m_hp;

  function automatic int first_in_order(input logic [7:0] v, input int low);
    for (int k = 0; k < 8; k++)
      if (v[(low + 1 + k) % 8]) return k;
    return 8;
  endfunction

  task automatic model_reset();
    m_low = 7; m_phase = 0; m_isr = 8'h00; m_int = 0; m_cp = 0; m_vv = 0;
    m_inta = 1; m_hp = 0;
  endtask

  task automatic model_step();
    logic fall, rise;
    int kr, ki, pend_lvl, tgt, new_low;
    logic pend_ok;
    logic [7:0] set_m, clr_m;
    fall = m_inta & ~inta_n;
    rise = ~m_inta & inta_n;
    kr = first_in_order(irr & ~imr, m_low);
    ki = first_in_order(m_isr, m_low);
    pend_ok  = (kr < 8) && (kr < ki);
    pend_lvl = (m_low + 1 + kr) % 8;
    set_m = 0; clr_m = 0; new_low = m_low;
    m_int = 0;
    case (m_phase)
      0: if (fall) begin
           m_hp = pend_ok ? pend_lvl : 7;
           if (pend_ok) set_m[pend_lvl] = 1;
           m_phase = 1;
         end else m_int = pend_ok;
      1: if (rise) begin m_cp = 1; m_phase = 2; end
      2: if (fall) begin m_vv = 1; m_phase = 3; end
      default: if (rise) begin
           m_vv = 0; m_cp = 0; m_phase = 0;
`ifdef PIC_AUTO_EOI_EN
           if (aeoi && m_isr[m_hp]) begin
             clr_m[m_hp] = 1;
             if (rotate_on_eoi) new_low = m_hp;
           end
`endif
         end
    endcase
    if (eoi_valid) begin
      tgt = eoi_specific ? int'(eoi_level) : ((ki < 8) ? (m_low + 1 + ki) % 8 : -1);
      if (tgt >= 0 && m_isr[tgt]) begin
        clr_m[tgt] = 1;
        if (rotate_on_eoi) new_low = tgt;
      end
    end
    m_isr  = (m_isr & ~clr_m) | set_m;
    m_low  = new_low;
    m_inta = inta_n;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    irr = 0; imr = 0; inta_n = 1; eoi_valid = 0; eoi_specific = 0;
    eoi_level = 0; rotate_on_eoi = 0; aeoi = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    model_reset();
  endtask

  // Full two-pulse INTA; irr_after models the request register dropping its bit.
  task automatic ack_pair(input logic [7:0] irr_after);
    inta_n = 0; cyc();
    inta_n = 1; irr = irr_after; cyc();
    inta_n = 0; cyc();
    inta_n = 1; cyc();
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl, input logic rot);
    eoi_valid = 1; eoi_specific = spec; eoi_level = lvl; rotate_on_eoi = rot;
    cyc();
    eoi_valid = 0; eoi_specific = 0; rotate_on_eoi = 0;
  endtask

  typedef struct {
    logic [7:0] irr, imr;
    logic       inta_n, ev, es;
    logic [2:0] el;
    logic       rot;
    logic       e_int;
    logic [2:0] e_hp;
    logic       e_cp, e_vv;
    logic [7:0] e_isr;
  } vec_t;

  function automatic vec_t mk(logic [7:0] i, logic [7:0] m, logic a, logic ev, logic es,
                              logic [2:0] el, logic rot, logic ei, logic [2:0] hp,
                              logic cp, logic vv, logic [7:0] is);
    vec_t v;
    v.irr = i; v.imr = m; v.inta_n = a; v.ev = ev; v.es = es; v.el = el; v.rot = rot;
    v.e_int = ei; v.e_hp = hp; v.e_cp = cp; v.e_vv = vv; v.e_isr = is;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    logic [13:0] exp_v, act_v;

    // priority, nesting, EOI, masking/spurious walk from reset (lowest = 7)
    tbl[0]  = mk(8'h24, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00);
    tbl[1]  = mk(8'h24, 8'h00, 0, 0, 0, 0, 0, 0, 2, 0, 0, 8'h04);
    tbl[2]  = mk(8'h24, 8'h00, 0, 0, 0, 0, 0, 0, 2, 0, 0, 8'h04);
    tbl[3]  = mk(8'h20, 8'h00, 1, 0, 0, 0, 0, 0, 2, 1, 0, 8'h04);
    tbl[4]  = mk(8'h20, 8'h00, 0, 0, 0, 0, 0, 0, 2, 1, 1, 8'h04);
    tbl[5]  = mk(8'h20, 8'h00, 1, 0, 0, 0, 0, 0, 2, 0, 0, 8'h04);
    tbl[6]  = mk(8'h20, 8'h00, 1, 0, 0, 0, 0, 0, 2, 0, 0, 8'h04);
    tbl[7]  = mk(8'h08, 8'h00, 1, 0, 0, 0, 0, 0, 2, 0, 0, 8'h04);
    tbl[8]  = mk(8'h02, 8'h00, 1, 0, 0, 0, 0, 1, 2, 0, 0, 8'h04);
    tbl[9]  = mk(8'h02, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h06);
    tbl[10] = mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 1, 1, 0, 8'h06);
    tbl[11] = mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'h06);
    tbl[12] = mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h06);
    tbl[13] = mk(8'h00, 8'h00, 1, 1, 0, 0, 0, 0, 1, 0, 0, 8'h04);
    tbl[14] = mk(8'h00, 8'h00, 1, 1, 1, 2, 0, 0, 1, 0, 0, 8'h00);
    tbl[15] = mk(8'h01, 8'h01, 1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[16] = mk(8'h01, 8'h01, 0, 0, 0, 0, 0, 0, 7, 0, 0, 8'h00);
    tbl[17] = mk(8'h01, 8'h01, 1, 0, 0, 0, 0, 0, 7, 1, 0, 8'h00);
    tbl[18] = mk(8'h01, 8'h01, 0, 0, 0, 0, 0, 0, 7, 1, 1, 8'h00);
    tbl[19] = mk(8'h01, 8'h01, 1, 0, 0, 0, 0, 0, 7, 0, 0, 8'h00);

    idle_inputs();
    reset = 1;
    cyc(); cyc();
    chk("rst_int", int_out, 0);
    chk("rst_hp", highest_priority, 0);
    chk("rst_cp", current_pulse, 0);
    chk("rst_vv", vector_valid, 0);
    chk("rst_isr", isr, 0);
    chk("rst_state", dbg_state, IDLE);
    reset = 0;
    cyc();

    for (int i = 0; i < 20; i++) begin
      irr = tbl[i].irr; imr = tbl[i].imr; inta_n = tbl[i].inta_n;
      eoi_valid = tbl[i].ev; eoi_specific = tbl[i].es; eoi_level = tbl[i].el;
      rotate_on_eoi = tbl[i].rot;
      cyc();
      chk($sformatf("tbl%0d_int", i), int_out, tbl[i].e_int);
      chk($sformatf("tbl%0d_hp", i), highest_priority, tbl[i].e_hp);
      chk($sformatf("tbl%0d_cp", i), current_pulse, tbl[i].e_cp);
      chk($sformatf("tbl%0d_vv", i), vector_valid, tbl[i].e_vv);
      chk($sformatf("tbl%0d_isr", i), isr, tbl[i].e_isr);
    end
    idle_inputs();

    // rotation: non-specific EOI with rotate makes IR0 lowest, so IR7 wins over IR0
    do_reset();
    irr = 8'h01; cyc();
    chk("rot_int", int_out, 1);
    ack_pair(8'h00);
    chk("rot_isr_set", isr, 8'h01);
    eoi(0, 0, 1);
    chk("rot_isr_clr", isr, 8'h00);
    irr = 8'h81; cyc();
    chk("rot_int2", int_out, 1);
    ack_pair(8'h01);
    chk("rot_hp", highest_priority, 7);
    chk("rot_isr", isr, 8'h80);

    // specific EOI on set and on clear bits
    do_reset();
    irr = 8'h20; cyc();
    ack_pair(8'h00);
    irr = 8'h01; cyc();
    chk("spec_nest_int", int_out, 1);
    ack_pair(8'h00);
    chk("spec_isr21", isr, 8'h21);
    eoi(1, 5, 0);
    chk("spec_eoi5", isr, 8'h01);
    eoi(1, 3, 0);
    chk("spec_eoi3", isr, 8'h01);

    // reset while in GAP aborts the sequence
    do_reset();
    irr = 8'h10; cyc();
    inta_n = 0; cyc();
    inta_n = 1; cyc();
    chk("gap_state", dbg_state, GAP);
    chk("gap_isr", isr, 8'h10);
    reset = 1; cyc();
    chk("gaprst_state", dbg_state, IDLE);
    chk("gaprst_isr", isr, 0);
    chk("gaprst_cp", current_pulse, 0);
    chk("gaprst_vv", vector_valid, 0);
    chk("gaprst_hp", highest_priority, 0);
    chk("gaprst_int", int_out, 0);
    reset = 0; irr = 0;

`ifdef PIC_AUTO_EOI_EN
    do_reset();
    aeoi = 1;
    irr = 8'h10; cyc();
    inta_n = 0; cyc();
    chk("aeoi_isr_set", isr, 8'h10);
    inta_n = 1; irr = 0; cyc();
    inta_n = 0; cyc();
    inta_n = 1; cyc();
    chk("aeoi_isr_clr", isr, 8'h00);
    aeoi = 0;
`endif

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      irr           = 8'($urandom);
      imr           = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
      eoi_valid     = ($urandom_range(0, 5) == 0);
      eoi_specific  = 1'($urandom);
      eoi_level     = 3'($urandom);
      rotate_on_eoi = 1'($urandom);
      aeoi          = 1'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1;
        cyc();
        reset = 0;
        model_reset();
      end else begin
        model_step();
        cyc();
      end
      exp_v = {m_int, 3'(m_hp), m_cp, m_vv, m_isr};
      act_v = {int_out, highest_priority, current_pulse, vector_valid, isr};
      chk($sformatf("rand%0d", n), act_v, exp_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
